// File: rtl/riscv_obi_prefetcher.sv
// rtl/riscv_obi_prefetcher.sv - OBI instruction prefetcher with stale-response flush and 16/32-bit realignment
module riscv_obi_prefetcher #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        fetch_ready_i,
  output logic        fetch_valid_o,
  output logic [31:0] fetch_rdata_o,
  output logic [31:0] fetch_addr_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  output logic        busy_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = CW + 1;

  typedef enum logic {S_IDLE, S_WAIT_GNT} state_e;

  state_e              state_q;
  logic [31:0]         addr_q;
  logic [31:0]         wait_addr_q;
  logic                stale_q;
  logic [31:0]         pc_q, pc_d;
  logic [CW-1:0]       out_q, out_d;
  logic [CW-1:0]       flush_q, flush_d;
  logic [CW-1:0]       fifo_cnt_q, fifo_cnt_d;
  logic [CW-1:0]       wr_idx;
  logic [DEPTH*32-1:0] fifo_q, fifo_d;

  logic [31:0] w0, w1, branch_word;
  logic        is_comp, need_two, avail, consume, pop, push, drop;
  logic        grant, old_gnt;
  logic [OW-1:0] occ;
  logic        unused_err;

  assign unused_err  = instr_err_i;
  assign w0          = fifo_q[31:0];
  assign w1          = fifo_q[63:32];
  assign branch_word = {branch_addr_i[31:2], 2'b00};

  // Aligner: pick the instruction at pc from the FIFO head (and next word when it straddles)
  always_comb begin
    is_comp       = pc_q[1] ? (w0[17:16] != 2'b11) : (w0[1:0] != 2'b11);
    need_two      = pc_q[1] && !is_comp;
    avail         = need_two ? (fifo_cnt_q >= CW'(2)) : (fifo_cnt_q != '0);
    fetch_valid_o = avail && !branch_i;
    fetch_rdata_o = 32'h0;
    case ({pc_q[1], is_comp})
      2'b01:   fetch_rdata_o = {16'h0, w0[15:0]};
      2'b00:   fetch_rdata_o = w0;
      2'b11:   fetch_rdata_o = {16'h0, w0[31:16]};
      default: fetch_rdata_o = {w1[15:0], w0[31:16]};
    endcase
    consume = fetch_valid_o && fetch_ready_i;
    // a compressed instruction in the low half leaves the word for its upper half
    pop     = consume && (pc_q[1] || !is_comp);
  end

  // Request side: the slot freed by this cycle's pop is credited so a 1-cycle memory streams back-to-back
  always_comb begin
    occ          = OW'(out_q) + OW'(fifo_cnt_q) - OW'(pop);
    instr_req_o  = 1'b0;
    instr_addr_o = addr_q;
    if (state_q == S_WAIT_GNT) begin
      instr_req_o  = 1'b1;
      instr_addr_o = wait_addr_q;
    end else if (branch_i) begin
      instr_req_o  = (out_q < CW'(DEPTH));
      instr_addr_o = branch_word;
    end else begin
      instr_req_o  = req_i && (occ < OW'(DEPTH));
    end
    grant   = instr_req_o && instr_gnt_i;
    old_gnt = (state_q == S_WAIT_GNT) && instr_gnt_i;
  end

  // Counter, flush and FIFO next-state; responses owed to the old stream are dropped
  always_comb begin
    drop  = instr_rvalid_i && (flush_q != '0);
    push  = instr_rvalid_i && (flush_q == '0) && !branch_i;
    out_d = out_q + CW'(grant) - CW'(instr_rvalid_i);
    if (branch_i) begin
      flush_d = out_q - CW'(instr_rvalid_i) + CW'(old_gnt);
    end else begin
      flush_d = flush_q - CW'(drop) + CW'(old_gnt && stale_q);
    end
    fifo_d = pop ? (fifo_q >> 32) : fifo_q;
    wr_idx = fifo_cnt_q - CW'(pop);
    for (int i = 0; i < DEPTH; i++) begin
      if (push && (wr_idx == CW'(i))) begin
        fifo_d[i*32 +: 32] = instr_rdata_i;
      end
    end
    fifo_cnt_d = branch_i ? '0 : (fifo_cnt_q - CW'(pop) + CW'(push));
    if (branch_i) begin
      pc_d = branch_addr_i;
    end else if (consume) begin
      pc_d = pc_q + (is_comp ? 32'd2 : 32'd4);
    end else begin
      pc_d = pc_q;
    end
  end

  // Request FSM: holds an ungranted request stable and remembers a branch that arrived meanwhile
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= 32'h0;
      wait_addr_q <= 32'h0;
      stale_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (instr_req_o) begin
            if (instr_gnt_i) begin
              addr_q <= instr_addr_o + 32'd4;
            end else begin
              state_q     <= S_WAIT_GNT;
              wait_addr_q <= instr_addr_o;
            end
          end else if (branch_i) begin
            addr_q <= branch_word;
          end
        end
        default: begin
          if (instr_gnt_i) begin
            state_q <= S_IDLE;
            stale_q <= 1'b0;
            if (branch_i) begin
              addr_q <= branch_word;
            end else if (!stale_q) begin
              addr_q <= wait_addr_q + 32'd4;
            end
          end else if (branch_i) begin
            addr_q  <= branch_word;
            stale_q <= 1'b1;
          end
        end
      endcase
    end
  end

  // Datapath registers: counters, FIFO storage and the IF-side pc
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      flush_q    <= '0;
      fifo_cnt_q <= '0;
      fifo_q     <= '0;
      pc_q       <= 32'h0;
    end else begin
      out_q      <= out_d;
      flush_q    <= flush_d;
      fifo_cnt_q <= fifo_cnt_d;
      fifo_q     <= fifo_d;
      pc_q       <= pc_d;
    end
  end

  assign fetch_addr_o = pc_q;
  assign busy_o       = (state_q == S_WAIT_GNT) || (out_q != '0);

endmodule

// File: tb/tb_riscv_obi_prefetcher.sv
// tb/tb_riscv_obi_prefetcher.sv - directed checks of the OBI prefetcher
module tb_riscv_obi_prefetcher;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [31:0] branch_addr_i = 32'h0;
  logic        fetch_ready_i = 1'b0;
  logic        fetch_valid_o;
  logic [31:0] fetch_rdata_o;
  logic [31:0] fetch_addr_o;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        gnt = 1'b1;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic        busy_o;
  logic        resp_en = 1'b1;

  riscv_obi_prefetcher #(.DEPTH(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_i         (req_i),
    .branch_i      (branch_i),
    .branch_addr_i (branch_addr_i),
    .fetch_ready_i (fetch_ready_i),
    .fetch_valid_o (fetch_valid_o),
    .fetch_rdata_o (fetch_rdata_o),
    .fetch_addr_o  (fetch_addr_o),
    .instr_req_o   (instr_req_o),
    .instr_addr_o  (instr_addr_o),
    .instr_gnt_i   (gnt),
    .instr_rvalid_i(rvalid),
    .instr_rdata_i (rdata),
    .instr_err_i   (1'b0),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  logic [31:0] pend [$];
  logic [31:0] resp_a;
  int          gcount;

  // Memory model: grant as driven by the bench, respond in order one cycle later while resp_en is high
  always @(posedge clk) begin
    if (!rst_n) begin
      pend.delete();
      gcount = 0;
      rvalid <= 1'b0;
    end else begin
      if (instr_req_o && gnt) begin
        pend.push_back(instr_addr_o);
        gcount++;
      end
      if (resp_en && pend.size() > 0) begin
        resp_a = pend.pop_front();
        rvalid <= 1'b1;
        rdata  <= mem[resp_a[9:2]];
      end else begin
        rvalid <= 1'b0;
      end
    end
  end

  int nvec = 0;
  int nfail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_i = 1'b0;
    branch_i = 1'b0;
    branch_addr_i = 32'h0;
    fetch_ready_i = 1'b0;
    gnt = 1'b1;
    resp_en = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = (32'(i) << 16) | 32'h13;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] rdata;
    int          len;
    int          lat;
  } vec_t;

  vec_t vt [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] idx;
    int lat;
    bit found;

    vt[0] = '{32'h0000_0080, 32'h0000_0013, 32'h0000_0000, 32'h0000_0013, 4, 2};
    vt[1] = '{32'h0000_0100, 32'h4501_4501, 32'h0000_0000, 32'h0000_4501, 2, 2};
    vt[2] = '{32'h0000_0102, 32'h4501_4501, 32'h0000_0000, 32'h0000_4501, 2, 2};
    vt[3] = '{32'h0000_0102, 32'h0093_0000, 32'hABCD_0000, 32'h0000_0093, 4, 3};
    vt[4] = '{32'h0000_0104, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 4, 2};
    vt[5] = '{32'h0000_0206, 32'hFFFF_1234, 32'h5678_ABCD, 32'hABCD_FFFF, 4, 3};
    vt[6] = '{32'h0000_020A, 32'h0002_0000, 32'h0000_0000, 32'h0000_0002, 2, 2};
    vt[7] = '{32'hFFFF_FFFE, 32'h0003_0000, 32'h0000_1111, 32'h1111_0003, 4, 3};

    // reset state
    do_reset();
    @(negedge clk);
    chk("reset instr_req_o", 32'(instr_req_o), 32'h0);
    chk("reset instr_addr_o", instr_addr_o, 32'h0);
    chk("reset fetch_valid_o", 32'(fetch_valid_o), 32'h0);
    chk("reset fetch_rdata_o", fetch_rdata_o, 32'h0);
    chk("reset fetch_addr_o", fetch_addr_o, 32'h0);
    chk("reset busy_o", 32'(busy_o), 32'h0);

    // branch to 0x80: same-cycle request, data two cycles later, then sequential request
    do_reset();
    mem[8'h20] = 32'h0000_0013;
    req_i = 1'b1; branch_i = 1'b1; branch_addr_i = 32'h80;
    @(negedge clk);
    chk("br80 c0 instr_req_o", 32'(instr_req_o), 32'h1);
    chk("br80 c0 instr_addr_o", instr_addr_o, 32'h80);
    chk("br80 c0 fetch_valid_o", 32'(fetch_valid_o), 32'h0);
    nxt(); branch_i = 1'b0;
    @(negedge clk);
    chk("br80 c1 instr_addr_o", instr_addr_o, 32'h84);
    chk("br80 c1 fetch_valid_o", 32'(fetch_valid_o), 32'h0);
    nxt(); req_i = 1'b0;
    @(negedge clk);
    chk("br80 c2 fetch_valid_o", 32'(fetch_valid_o), 32'h1);
    chk("br80 c2 fetch_rdata_o", fetch_rdata_o, 32'h13);
    chk("br80 c2 fetch_addr_o", fetch_addr_o, 32'h80);

    // aligner vectors
    for (int k = 0; k < 8; k++) begin
      do_reset();
      idx = vt[k].pc[9:2];
      mem[idx] = vt[k].w0;
      idx = idx + 8'd1;
      mem[idx] = vt[k].w1;
      req_i = 1'b1; branch_i = 1'b1; branch_addr_i = vt[k].pc;
      @(negedge clk);
      chk($sformatf("vec%0d valid in branch cycle", k), 32'(fetch_valid_o), 32'h0);
      nxt(); branch_i = 1'b0;
      lat = 0; found = 1'b0;
      for (int c = 1; c <= 10 && !found; c++) begin
        @(negedge clk);
        if (fetch_valid_o) begin
          found = 1'b1;
          lat = c;
        end else begin
          nxt();
        end
      end
      chk($sformatf("vec%0d latency", k), 32'(lat), 32'(vt[k].lat));
      chk($sformatf("vec%0d rdata", k), fetch_rdata_o, vt[k].rdata);
      chk($sformatf("vec%0d addr", k), fetch_addr_o, vt[k].pc);
      nxt(); fetch_ready_i = 1'b1;
      nxt(); fetch_ready_i = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d next pc", k), fetch_addr_o, vt[k].pc + 32'(vt[k].len));
    end

    // two compressed halves of one word: two handshakes, exactly one pop
    do_reset();
    mem[8'h40] = 32'h4501_4501;
    branch_i = 1'b1; branch_addr_i = 32'h100; fetch_ready_i = 1'b1;
    nxt(); branch_i = 1'b0;
    @(negedge clk);
    chk("pair c1 busy_o", 32'(busy_o), 32'h1);
    nxt();
    @(negedge clk);
    chk("pair c2 valid", 32'(fetch_valid_o), 32'h1);
    chk("pair c2 rdata", fetch_rdata_o, 32'h4501);
    chk("pair c2 addr", fetch_addr_o, 32'h100);
    nxt();
    @(negedge clk);
    chk("pair c3 valid", 32'(fetch_valid_o), 32'h1);
    chk("pair c3 rdata", fetch_rdata_o, 32'h4501);
    chk("pair c3 addr", fetch_addr_o, 32'h102);
    nxt();
    @(negedge clk);
    chk("pair c4 valid", 32'(fetch_valid_o), 32'h0);
    chk("pair c4 addr", fetch_addr_o, 32'h104);
    chk("pair c4 busy_o", 32'(busy_o), 32'h0);
    chk("pair c4 instr_req_o", 32'(instr_req_o), 32'h0);

    // branch while waiting for grant: address held, old response discarded
    do_reset();
    mem[8'h10] = 32'h1111_1113;
    mem[8'h80] = 32'h2222_2213;
    req_i = 1'b1; gnt = 1'b0; branch_i = 1'b1; branch_addr_i = 32'h40;
    @(negedge clk);
    chk("wg c0 instr_req_o", 32'(instr_req_o), 32'h1);
    chk("wg c0 instr_addr_o", instr_addr_o, 32'h40);
    nxt(); branch_addr_i = 32'h200;
    @(negedge clk);
    chk("wg c1 instr_addr_o", instr_addr_o, 32'h40);
    chk("wg c1 fetch_valid_o", 32'(fetch_valid_o), 32'h0);
    nxt(); branch_i = 1'b0;
    @(negedge clk);
    chk("wg c2 instr_addr_o", instr_addr_o, 32'h40);
    chk("wg c2 busy_o", 32'(busy_o), 32'h1);
    nxt(); gnt = 1'b1;
    @(negedge clk);
    chk("wg c3 instr_req_o", 32'(instr_req_o), 32'h1);
    chk("wg c3 instr_addr_o", instr_addr_o, 32'h40);
    nxt();
    @(negedge clk);
    chk("wg c4 instr_addr_o", instr_addr_o, 32'h200);
    chk("wg c4 instr_req_o", 32'(instr_req_o), 32'h1);
    nxt();
    @(negedge clk);
    chk("wg c5 fetch_valid_o", 32'(fetch_valid_o), 32'h0);
    nxt();
    @(negedge clk);
    chk("wg c6 fetch_valid_o", 32'(fetch_valid_o), 32'h1);
    chk("wg c6 fetch_rdata_o", fetch_rdata_o, 32'h2222_2213);
    chk("wg c6 fetch_addr_o", fetch_addr_o, 32'h200);

    // branch with two transactions outstanding: both late responses dropped
    do_reset();
    mem[8'h00] = 32'hBAD0_BAD3;
    mem[8'h01] = 32'hBAD1_BAD3;
    mem[8'hC0] = 32'h3333_3333;
    resp_en = 1'b0; req_i = 1'b1; branch_i = 1'b1; branch_addr_i = 32'h0;
    nxt(); branch_i = 1'b0;
    @(negedge clk);
    chk("fl c1 instr_addr_o", instr_addr_o, 32'h4);
    nxt(); branch_i = 1'b1; branch_addr_i = 32'h300;
    @(negedge clk);
    chk("fl c2 instr_req_o", 32'(instr_req_o), 32'h0);
    nxt(); branch_i = 1'b0; resp_en = 1'b1;
    @(negedge clk);
    chk("fl c3 instr_req_o", 32'(instr_req_o), 32'h0);
    chk("fl c3 fetch_valid_o", 32'(fetch_valid_o), 32'h0);
    nxt();
    @(negedge clk);
    chk("fl c4 fetch_valid_o", 32'(fetch_valid_o), 32'h0);
    nxt();
    @(negedge clk);
    chk("fl c5 fetch_valid_o", 32'(fetch_valid_o), 32'h0);
    chk("fl c5 instr_req_o", 32'(instr_req_o), 32'h1);
    chk("fl c5 instr_addr_o", instr_addr_o, 32'h300);
    nxt();
    @(negedge clk);
    chk("fl c6 fetch_valid_o", 32'(fetch_valid_o), 32'h0);
    nxt();
    @(negedge clk);
    chk("fl c7 fetch_valid_o", 32'(fetch_valid_o), 32'h1);
    chk("fl c7 fetch_rdata_o", fetch_rdata_o, 32'h3333_3333);
    chk("fl c7 fetch_addr_o", fetch_addr_o, 32'h300);

    // IF stalled with continuous grant/response: fetching stops at two words
    do_reset();
    req_i = 1'b1; branch_i = 1'b1; branch_addr_i = 32'h0;
    nxt(); branch_i = 1'b0;
    repeat (9) nxt();
    @(negedge clk);
    chk("stall grant count", 32'(gcount), 32'd2);
    chk("stall instr_req_o", 32'(instr_req_o), 32'h0);
    chk("stall busy_o", 32'(busy_o), 32'h0);
    nxt(); req_i = 1'b0; fetch_ready_i = 1'b1;
    @(negedge clk);
    chk("stall drain0 rdata", fetch_rdata_o, 32'h0000_0013);
    chk("stall drain0 addr", fetch_addr_o, 32'h0);
    nxt();
    @(negedge clk);
    chk("stall drain1 valid", 32'(fetch_valid_o), 32'h1);
    chk("stall drain1 rdata", fetch_rdata_o, 32'h0001_0013);
    chk("stall drain1 addr", fetch_addr_o, 32'h4);
    nxt();
    @(negedge clk);
    chk("stall drained valid", 32'(fetch_valid_o), 32'h0);
    chk("stall drained addr", fetch_addr_o, 32'h8);
    chk("stall final grant count", 32'(gcount), 32'd2);

    // back-to-back 32-bit stream with 1-cycle memory
    do_reset();
    req_i = 1'b1; fetch_ready_i = 1'b1; branch_i = 1'b1; branch_addr_i = 32'h0;
    nxt(); branch_i = 1'b0;
    nxt();
    for (int c = 2; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("stream c%0d valid", c), 32'(fetch_valid_o), 32'h1);
      chk($sformatf("stream c%0d addr", c), fetch_addr_o, 32'(4 * (c - 2)));
      chk($sformatf("stream c%0d rdata", c), fetch_rdata_o, (32'(c - 2) << 16) | 32'h13);
      nxt();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/riscv_obi_prefetcher.md
# riscv_obi_prefetcher

Instruction prefetcher that sits directly upstream of the IF stage, between the OBI instruction port and the IF offset FSM. It issues word-aligned OBI fetches, buffers responses in a small FIFO and discards stale responses after a branch. It also realigns 16/32-bit instructions so that each fetch handshake delivers exactly one instruction and its PC.

## Interface
- DEPTH, 2: FIFO words; also the cap on FIFO occupancy plus outstanding transactions.
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_i  in  1  fetch enable; when low, no new OBI requests start
- branch_i  in  1  redirect fetch
- branch_addr_i  in  32  redirect target, halfword aligned
- fetch_ready_i  in  1  IF consumes current instruction
- fetch_valid_o  out  1  instruction available
- fetch_rdata_o  out  32  instruction (compressed: upper 16 bits zero)
- fetch_addr_o  out  32  PC of fetch_rdata_o
- instr_req_o  out  1  OBI request
- instr_addr_o  out  32  OBI address, bits [1:0] always 0
- instr_gnt_i  in  1  OBI grant
- instr_rvalid_i  in  1  OBI response valid
- instr_rdata_i  in  32  OBI response data
- instr_err_i  in  1  ignored
- busy_o  out  1  request pending or transactions outstanding

## Operation
- Request FSM states:
  - IDLE: instr_req_o = req_i && (outstanding + fifo_cnt < DEPTH), or branch_i (always allowed if outstanding < DEPTH). Address is {branch_addr_i[31:2],2'b00} when branch_i, else addr_q.
  - IDLE, request not granted: go to WAIT_GNT.
  - IDLE, request granted: addr_q <= issued address + 4.
  - WAIT_GNT: instr_req_o=1 and instr_addr_o held (OBI stability) until gnt. On gnt: addr_q <= addr + 4, go to IDLE.
  - Branch during WAIT_GNT: record {branch_addr[31:2],00} in addr_q and set stale_pending. When the pending request is granted, its response is counted as stale, and the next request uses the branch address.
- Outstanding counter 0..DEPTH: +1 on req&gnt, −1 on rvalid, both in one cycle gives net 0.
- Flush: on branch_i:
  - FIFO is cleared.
  - flush_cnt <= outstanding − (rvalid ? 1 : 0) + (old-address grant this cycle ? 1 : 0).
  - fetch_addr_o <= branch_addr_i.
  - An rvalid while flush_cnt > 0 is dropped and decrements flush_cnt.
- FIFO: rvalid data with flush_cnt == 0 is pushed. Occupancy can never exceed DEPTH because of the request cap.
- Aligner, with pc = fetch_addr_o and w0/w1 = FIFO head/next:
  - pc[1]=0, w0[1:0]!=11: compressed instruction {16'h0, w0[15:0]}, valid when fifo_cnt≥1. Consume: pc+=2, no pop.
  - pc[1]=0, 32-bit: w0, valid when fifo_cnt≥1. Consume: pc+=4, pop 1.
  - pc[1]=1, w0[17:16]!=11: compressed instruction {16'h0, w0[31:16]}, valid when fifo_cnt≥1. Consume: pc+=2, pop 1.
  - pc[1]=1, 32-bit: {w1[15:0], w0[31:16]}, valid when fifo_cnt≥2. Consume: pc+=4, pop 1.
- fetch_valid_o is forced 0 in any cycle with branch_i. Branch wins over fetch_ready_i.
- Addresses wrap modulo 2^32 (0xFFFFFFFC + 4 = 0).
- Pop and push in the same cycle are allowed; data shifts correctly.
- busy_o = (state==WAIT_GNT) || outstanding != 0.

## Timing
- Reset values: instr_req_o=0, instr_addr_o=0, fetch_valid_o=0, fetch_rdata_o=0, fetch_addr_o=0, busy_o=0. FIFO empty, counters 0, state IDLE.
- Branch request is issued combinationally in the branch_i cycle (IDLE only).
- Response to IF: rvalid in cycle N gives fetch_valid_o in N+1 (registered, no bypass).
- Minimum branch-to-instruction latency, with gnt in cycle 0 and rvalid in cycle 1: fetch_valid_o in cycle 2.
- A sustained stream of 32-bit instructions with 1-cycle memory and DEPTH=2: 1 instruction/cycle.
- req_i falling: no new requests. A request already in WAIT_GNT completes and its response is stored.
- Reset mid-transaction: all state cleared. Late rvalids after reset are a system error and are not handled.

## Test plan
- Reset, req_i=1, branch_i to 0x80, gnt same cycle, rvalid next cycle with 0x00000013 -> instr_addr_o=0x80 in cycle 0; fetch_valid_o=1, rdata=0x00000013, addr=0x80 in cycle 2; next request to 0x84.
- Word 0x45014501 at 0x100, fetch_ready_i=1 -> two handshakes: (0x100, 0x00004501), (0x102, 0x00004501); exactly one pop.
- Branch to 0x102, word0=0x00930000, word1=0xABCD0000 -> no valid until both words stored; then rdata=0x00000093, addr=0x102; next pc 0x106.
- gnt held low 3 cycles at 0x40, branch_i to 0x200 in cycle 1 -> instr_addr_o stays 0x40 until gnt; the 0x40 response is discarded; next request is 0x200; only 0x200 data is delivered.
- Branch with 2 outstanding (DEPTH=2) -> both later rvalids dropped, flush_cnt returns to 0, fetch_valid_o stays 0 until the new-target data arrives.
- fetch_ready_i=0, continuous gnt/rvalid -> fetch stalls after FIFO holds 2 words; outstanding+fifo_cnt never exceeds 2; busy_o=0 once idle.
